// File: rtl/cam_stream_gen_if.sv
// cam_stream_gen_if: control inputs and camera-side outputs of the
// synthetic camera stream generator, bundled as one port.
//   en          frame enable (level)
//   mode        pattern select: 0 solid, 1 bars, 2 red gradient, 3 checker
//   color       RGB444 value used by the solid pattern
//   CAM_pclk    pixel clock, clk/2, runs only while a frame is possible
//   CAM_vsync   frame sync, active high
//   CAM_href    line valid, active high
//   CAM_px_data byte stream, two bytes per pixel
//   frame_done  one-clk pulse at the end of each frame
// master: the generator. slave: the consumer that drives the controls.
interface cam_stream_gen_if;
  logic        en;
  logic [1:0]  mode;
  logic [11:0] color;
  logic        CAM_pclk;
  logic        CAM_vsync;
  logic        CAM_href;
  logic [7:0]  CAM_px_data;
  logic        frame_done;

  modport master (
    input  en, mode, color,
    output CAM_pclk, CAM_vsync, CAM_href, CAM_px_data, frame_done
  );

  modport slave (
    output en, mode, color,
    input  CAM_pclk, CAM_vsync, CAM_href, CAM_px_data, frame_done
  );
endinterface

// File: rtl/cam_stream_gen.sv
// cam_stream_gen: emulates an 8-bit parallel camera (OV7670-like timing)
// producing RGB444 test patterns.
//   clk  system clock (camera xclk domain)
//   rst  asynchronous active-low reset
//   cam  cam_stream_gen_if.master: en/mode/color in, CAM_* and frame_done out
// CAM_pclk is a divide-by-two phase flop. All frame state advances on the
// clk edge where CAM_pclk falls, so outputs are stable at each pclk rise.
module cam_stream_gen #(
  parameter int CAM_SCREEN_X = 160,
  parameter int CAM_SCREEN_Y = 120,
  parameter int VSYNC_LINES  = 3,
  parameter int VBP_LINES    = 17,
  parameter int VFP_LINES    = 10,
  parameter int HBLANK_PCLK  = 144
) (
  input  logic             clk,
  input  logic             rst,
  cam_stream_gen_if.master cam
);

  localparam int LINE_PCLK  = 2 * CAM_SCREEN_X + HBLANK_PCLK;
  localparam int VSYNC_PCLK = VSYNC_LINES * LINE_PCLK;
  localparam int VBP_PCLK   = VBP_LINES * LINE_PCLK;
  localparam int VFP_PCLK   = VFP_LINES * LINE_PCLK;
  localparam int MAX_A      = (VSYNC_PCLK > VBP_PCLK) ? VSYNC_PCLK : VBP_PCLK;
  localparam int MAX_B      = (MAX_A > VFP_PCLK) ? MAX_A : VFP_PCLK;
  localparam int CNT_MAX    = (MAX_B > HBLANK_PCLK) ? MAX_B : HBLANK_PCLK;
  localparam int CW         = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int XW         = (CAM_SCREEN_X > 2) ? $clog2(CAM_SCREEN_X) : 1;
  localparam int YW         = (CAM_SCREEN_Y > 2) ? $clog2(CAM_SCREEN_Y) : 1;

  localparam logic [CW-1:0] VSYNC_LAST = CW'(VSYNC_PCLK - 1);
  localparam logic [CW-1:0] VBP_LAST   = CW'(VBP_PCLK - 1);
  localparam logic [CW-1:0] VFP_LAST   = CW'(VFP_PCLK - 1);
  localparam logic [CW-1:0] HB_LAST    = CW'(HBLANK_PCLK - 1);
  localparam logic [XW-1:0] X_LAST     = XW'(CAM_SCREEN_X - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(CAM_SCREEN_Y - 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP} state_t;

  state_t        state;
  logic          ph;
  logic [CW-1:0] cnt;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic          byte_sel;
  logic          vsync_q, href_q, fd_q;
  logic [7:0]    data_q;
  logic [1:0]    mode_q;
  logic [11:0]   color_q;

  function automatic logic [11:0] pattern(input logic [1:0]  m,
                                          input logic [11:0] c,
                                          input logic [15:0] x,
                                          input logic        y3);
    logic [2:0] bar;
    pattern = 12'h000;
    case (m)
      2'd0: pattern = c;
      2'd1: begin
        bar     = 3'((32'(x) * 32'd8) / 32'(CAM_SCREEN_X));
        pattern = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
      end
      2'd2:    pattern = {x[7:4], 8'h00};
      default: pattern = (x[3] ^ y3) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  // Outputs are registered, so the pixel is computed for the byte slot that
  // becomes visible after this edge: inside a line that is the next byte,
  // on line entry it is byte 0 of pixel 0 (of the next line when in HBLANK).
  logic          tick, run, start_frame, next_sel, y_b3, y_low7, pix_y3;
  logic [XW-1:0] pix_x;
  logic [11:0]   pix;
  logic [7:0]    pix_byte;

  if (YW > 3) begin : g_ybit
    assign y_b3   = y_cnt[3];
    assign y_low7 = &y_cnt[2:0];
  end else begin : g_ybit_none
    assign y_b3   = 1'b0;
    assign y_low7 = 1'b0;
  end

  assign tick        = ph;
  assign run         = cam.en || (state != IDLE);
  assign start_frame = tick && cam.en &&
                       ((state == IDLE) || (state == VFP && cnt == VFP_LAST));
  assign next_sel    = (state == ACTIVE) ? ~byte_sel : 1'b0;
  assign pix_x       = (state == ACTIVE && byte_sel) ? x_cnt + XW'(1) : x_cnt;
  assign pix_y3      = y_b3 ^ ((state == HBLANK) && y_low7);
  assign pix         = pattern(mode_q, color_q, 16'(pix_x), pix_y3);
  assign pix_byte    = next_sel ? pix[7:0] : {4'h0, pix[11:8]};

  // Pattern selection is latched once per frame.
  always_ff @(posedge clk) begin
    if (start_frame) begin
      mode_q  <= cam.mode;
      color_q <= cam.color;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ph       <= 1'b0;
      cnt      <= '0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      byte_sel <= 1'b0;
      vsync_q  <= 1'b0;
      href_q   <= 1'b0;
      fd_q     <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      fd_q <= 1'b0;
      ph   <= run ? ~ph : 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (cam.en) begin
              state   <= VSYNC;
              vsync_q <= 1'b1;
              cnt     <= '0;
              y_cnt   <= '0;
            end
          end
          VSYNC: begin
            if (cnt == VSYNC_LAST) begin
              state   <= VBP;
              vsync_q <= 1'b0;
              cnt     <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          VBP: begin
            if (cnt == VBP_LAST) begin
              state  <= ACTIVE;
              href_q <= 1'b1;
              data_q <= pix_byte;
              cnt    <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ACTIVE: begin
            if (byte_sel && x_cnt == X_LAST) begin
              state    <= HBLANK;
              href_q   <= 1'b0;
              data_q   <= 8'h00;
              x_cnt    <= '0;
              byte_sel <= 1'b0;
            end else begin
              byte_sel <= ~byte_sel;
              if (byte_sel) x_cnt <= x_cnt + XW'(1);
              data_q <= pix_byte;
            end
          end
          HBLANK: begin
            if (cnt == HB_LAST) begin
              cnt <= '0;
              if (y_cnt == Y_LAST) begin
                state <= VFP;
              end else begin
                state  <= ACTIVE;
                href_q <= 1'b1;
                y_cnt  <= y_cnt + YW'(1);
                data_q <= pix_byte;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          VFP: begin
            if (cnt == VFP_LAST) begin
              fd_q <= 1'b1;
              cnt  <= '0;
              if (cam.en) begin
                state   <= VSYNC;
                vsync_q <= 1'b1;
                y_cnt   <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign cam.CAM_pclk    = ph;
  assign cam.CAM_vsync   = vsync_q;
  assign cam.CAM_href    = href_q;
  assign cam.CAM_px_data = data_q;
  assign cam.frame_done  = fd_q;

endmodule

// File: tb/tb_cam_stream_gen.sv
// tb_cam_stream_gen: drives cam_stream_gen with a reduced geometry so whole
// frames fit in a short run, captures every pixel at CAM_pclk rate into
// per-frame images and checks timing, byte format and pixel values.
module tb_cam_stream_gen;

  localparam int X   = 32;
  localparam int Y   = 12;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int VFP = 1;
  localparam int HB  = 8;
  localparam int L   = 2 * X + HB;

  logic clk;
  logic rst;

  cam_stream_gen_if cam ();

  cam_stream_gen #(
    .CAM_SCREEN_X (X),
    .CAM_SCREEN_Y (Y),
    .VSYNC_LINES  (VS),
    .VBP_LINES    (VBP),
    .VFP_LINES    (VFP),
    .HBLANK_PCLK  (HB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cam (cam)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  // Independent reference for a pixel value.
  function automatic logic [11:0] model_px(input int m, input logic [11:0] c,
                                           input int x, input int y);
    int bar;
    case (m)
      0: return c;
      1: begin
        bar = (x * 8) / X;
        return {(bar >= 4) ? 4'hF : 4'h0,
                ((bar / 2) % 2 == 1) ? 4'hF : 4'h0,
                (bar % 2 == 1) ? 4'hF : 4'h0};
      end
      2: return {4'((x / 16) % 16), 8'h00};
      default: return ((((x / 8) % 2) ^ ((y / 8) % 2)) == 1) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  // Monitor state: written only by the monitor process.
  logic [11:0] img [0:4][0:Y-1][0:X-1];
  int slot = 0;
  int vs_run = 0, last_vs_len = 0;
  int href_run = 0, gap_run = 0, row = 0;
  bit fall_valid = 0;
  int pulses = 0, bad_len = 0, bad_gap = 0, bad_zero = 0, bad_hi = 0, fd_total = 0;
  logic [3:0] rbuf = 4'h0;

  // One sample per pclk period: the negedge of clk while CAM_pclk is high.
  initial forever begin
    @(negedge clk);
    if (cam.frame_done) fd_total++;
    if (!rst) begin
      vs_run = 0; href_run = 0; gap_run = 0; fall_valid = 0;
    end else if (cam.CAM_pclk) begin
      if (cam.CAM_vsync) begin
        vs_run++; row = 0; fall_valid = 0;
      end else if (vs_run != 0) begin
        last_vs_len = vs_run; vs_run = 0;
      end
      if (cam.CAM_href) begin
        if (href_run == 0) begin
          pulses++;
          if (fall_valid && gap_run != HB) bad_gap++;
        end
        if (row < Y && href_run < 2 * X) begin
          if (href_run % 2 == 0) begin
            rbuf = cam.CAM_px_data[3:0];
            if (cam.CAM_px_data[7:4] != 4'h0) bad_hi++;
          end else begin
            img[slot][row][href_run / 2] = {rbuf, cam.CAM_px_data};
          end
        end
        href_run++;
        gap_run = 0;
      end else begin
        if (cam.CAM_px_data != 8'h00) bad_zero++;
        if (href_run != 0) begin
          if (href_run != 2 * X) bad_len++;
          href_run = 0; row++; fall_valid = 1; gap_run = 0;
        end
        gap_run++;
      end
    end
  end

  int s_pulses, s_bad_len, s_bad_gap, s_bad_zero, s_bad_hi, s_fd;

  task automatic snap();
    s_pulses = pulses; s_bad_len = bad_len; s_bad_gap = bad_gap;
    s_bad_zero = bad_zero; s_bad_hi = bad_hi; s_fd = fd_total;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk); #1;
      if (cam.frame_done) begin seen = 1; break; end
    end
    chk({nm, "_frame_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_vsync(input string nm);
    bit seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cam.CAM_vsync) begin seen = 1; break; end
    end
    chk({nm, "_vsync_seen"}, 32'(seen), 32'd1);
  endtask

  // Released with en=1: count clk edges until CAM_vsync rises.
  task automatic release_and_latency(input string nm);
    int lat = 0;
    rst = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (cam.CAM_vsync) begin lat = i; break; end
    end
    chk({nm, "_vsync_within_2clk"}, 32'(lat >= 1 && lat <= 2), 32'd1);
  endtask

  task automatic idle_check(input string nm);
    int hi = 0;
    repeat (2) @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      if (cam.CAM_pclk || cam.CAM_vsync) hi++;
    end
    chk({nm, "_idle_pclk_low"}, 32'(hi), 32'd0);
  endtask

  task automatic check_frame(input string nm, input int sl, input int m, input logic [11:0] c);
    int bad = 0;
    chk({nm, "_vsync_len"},   32'(last_vs_len), 32'(VS * L));
    chk({nm, "_href_pulses"}, 32'(pulses - s_pulses), 32'(Y));
    chk({nm, "_href_len"},    32'(bad_len - s_bad_len), 32'd0);
    chk({nm, "_hblank_gap"},  32'(bad_gap - s_bad_gap), 32'd0);
    chk({nm, "_blank_zero"},  32'(bad_zero - s_bad_zero), 32'd0);
    chk({nm, "_byte0_hi"},    32'(bad_hi - s_bad_hi), 32'd0);
    chk({nm, "_frame_done"},  32'(fd_total - s_fd), 32'd1);
    for (int yy = 0; yy < Y; yy++)
      for (int xx = 0; xx < X; xx++)
        if (img[sl][yy][xx] !== model_px(m, c, xx, yy)) bad++;
    chk({nm, "_image"}, 32'(bad), 32'd0);
  endtask

  typedef struct {
    int          sl;
    int          x;
    int          y;
    logic [11:0] exp;
  } vec_t;

  vec_t vt [0:21];

  initial begin
    vt[0]  = '{0, 0, 0, 12'hA5C};  vt[1]  = '{0, 31, 11, 12'hA5C};
    vt[2]  = '{1, 0, 0, 12'h000};  vt[3]  = '{1, 3, 0, 12'h000};
    vt[4]  = '{1, 4, 0, 12'h00F};  vt[5]  = '{1, 8, 0, 12'h0F0};
    vt[6]  = '{1, 12, 5, 12'h0FF}; vt[7]  = '{1, 16, 0, 12'hF00};
    vt[8]  = '{1, 20, 1, 12'hF0F}; vt[9]  = '{1, 27, 2, 12'hFF0};
    vt[10] = '{1, 31, 0, 12'hFFF}; vt[11] = '{2, 15, 0, 12'h000};
    vt[12] = '{2, 16, 3, 12'h100}; vt[13] = '{2, 31, 11, 12'h100};
    vt[14] = '{3, 8, 0, 12'hFFF};  vt[15] = '{3, 8, 8, 12'h000};
    vt[16] = '{3, 0, 0, 12'h000};  vt[17] = '{3, 0, 8, 12'hFFF};
    vt[18] = '{3, 24, 9, 12'h000}; vt[19] = '{3, 7, 8, 12'hFFF};
    vt[20] = '{4, 0, 0, 12'h000};  vt[21] = '{4, 8, 0, 12'hFFF};

    rst = 1'b0; cam.en = 1'b0; cam.mode = 2'd0; cam.color = 12'h000;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({cam.CAM_pclk, cam.CAM_vsync, cam.CAM_href,
                              cam.CAM_px_data, cam.frame_done}), 32'd0);

    // Frame A: solid A5C, en dropped right after the frame starts.
    slot = 0; cam.color = 12'hA5C; cam.en = 1'b1; snap();
    release_and_latency("A");
    @(negedge clk); cam.en = 1'b0;
    wait_done("A");
    check_frame("A", 0, 0, 12'hA5C);
    idle_check("A");

    // Frame B: bars; mode changed mid-frame must not affect this frame.
    slot = 1; cam.mode = 2'd1; snap(); cam.en = 1'b1;
    wait_vsync("B");
    cam.mode = 2'd2;
    wait_done("B");
    check_frame("B", 1, 1, 12'h000);

    // Frame C follows back to back as red gradient; en dropped at line 6.
    slot = 2; snap();
    repeat (2 * (VS + VBP + 6) * L) @(negedge clk);
    cam.en = 1'b0; cam.mode = 2'd3;
    wait_done("C");
    check_frame("C", 2, 2, 12'h000);
    idle_check("C");

    // Frame D: checkerboard.
    slot = 3; snap(); cam.en = 1'b1;
    wait_vsync("D");
    cam.en = 1'b0;
    wait_done("D");
    check_frame("D", 3, 3, 12'h000);

    // Frame E: reset asserted during an active line, then restart.
    begin
      bit   hit = 0;
      int   fd_save;
      slot = 4; cam.mode = 2'd1; cam.en = 1'b1; snap();
      for (int i = 0; i < 4000; i++) begin
        @(negedge clk); #1;
        if (pulses - s_pulses >= 3 && cam.CAM_href) begin hit = 1; break; end
      end
      chk("E_reached_active", 32'(hit), 32'd1);
      fd_save = fd_total;
      rst = 1'b0; #1;
      chk("E_reset_outputs_now", 32'({cam.CAM_pclk, cam.CAM_vsync, cam.CAM_href,
                                      cam.CAM_px_data, cam.frame_done}), 32'd0);
      repeat (20) @(negedge clk);
      chk("E_reset_outputs_held", 32'({cam.CAM_pclk, cam.CAM_vsync, cam.CAM_href,
                                       cam.CAM_px_data, cam.frame_done}), 32'd0);
      chk("E_no_frame_done_on_abort", 32'(fd_total), 32'(fd_save));
      cam.mode = 2'd3; snap();
      release_and_latency("E");
      @(negedge clk); cam.en = 1'b0;
      wait_done("E");
      check_frame("E", 4, 3, 12'h000);
    end

    for (int i = 0; i < 22; i++) begin
      string nm;
      nm = $sformatf("pixel_s%0d_x%0d_y%0d", vt[i].sl, vt[i].x, vt[i].y);
      chk(nm, 32'(img[vt[i].sl][vt[i].y][vt[i].x]), 32'(vt[i].exp));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cam_stream_gen.md
CAM_STREAM_GEN -- requirements
Module: cam_stream_gen

Interface
REQ-001 Parameter CAM_SCREEN_X, default 160, active pixels per line.
REQ-002 Parameter CAM_SCREEN_Y, default 120, active lines per frame.
REQ-003 Parameter VSYNC_LINES, default 3, line periods with CAM_vsync high.
REQ-004 Parameter VBP_LINES, default 17, blank line periods after vsync and before the first active line.
REQ-005 Parameter VFP_LINES, default 10, blank line periods after the last active line.
REQ-006 Parameter HBLANK_PCLK, default 144, pclk periods with CAM_href low after each active line.
REQ-007 clk  in  1  system clock; CAM_xclk domain, 24 MHz nominal.
REQ-008 rst  in  1  asynchronous active-low reset.
REQ-009 en  in  1  level; frames start only while high.
REQ-010 mode  in  2  pattern select: 0 solid, 1 color bars, 2 red gradient, 3 checkerboard.
REQ-011 color  in  12  RGB444 value for mode 0.
REQ-012 CAM_pclk  out  1  pixel clock, clk/2.
REQ-013 CAM_vsync  out  1  frame sync, active high.
REQ-014 CAM_href  out  1  line valid, active high.
REQ-015 CAM_px_data  out  8  byte stream.
REQ-016 frame_done  out  1  one-clk pulse at the end of each frame.

Function
REQ-017 A phase flop shall toggle every clk, and CAM_pclk shall equal the phase flop; the module shall generate CAM_pclk only while en is high or a frame is in progress, and shall otherwise hold it low.
REQ-018 CAM_vsync, CAM_href and CAM_px_data shall change only on the clk edge where CAM_pclk goes 1->0, so that they are stable at every CAM_pclk rising edge.
REQ-019 The line period shall be L = 2*CAM_SCREEN_X + HBLANK_PCLK pclk periods (464 at defaults).
REQ-020 The FSM states shall be IDLE, VSYNC, VBP, ACTIVE, HBLANK and VFP.
REQ-021 IDLE -> VSYNC when en=1; VSYNC lasts VSYNC_LINES*L pclk.
REQ-022 VSYNC -> VBP; VBP lasts VBP_LINES*L pclk.
REQ-023 VBP -> ACTIVE; ACTIVE lasts 2*CAM_SCREEN_X pclk with CAM_href=1.
REQ-024 ACTIVE -> HBLANK; HBLANK lasts HBLANK_PCLK pclk with CAM_href=0.
REQ-025 HBLANK -> ACTIVE while the line count is below CAM_SCREEN_Y, else HBLANK -> VFP.
REQ-026 VFP lasts VFP_LINES*L pclk; at its end the module shall pulse frame_done and go to VSYNC if en=1, else to IDLE.
REQ-027 Dropping en mid-frame shall not abort the frame; the current frame shall always complete.
REQ-028 Each pixel shall be two consecutive bytes: first {4'b0000, R[3:0]}, then {G[3:0], B[3:0]}.
REQ-029 CAM_px_data shall be 8'h00 whenever CAM_href=0.
REQ-030 The pixel x counter shall run 0..CAM_SCREEN_X-1 per line and reset in HBLANK; the y counter shall run 0..CAM_SCREEN_Y-1 and reset in VSYNC.
REQ-031 mode and color shall be sampled at VSYNC entry and held constant for the whole frame.
REQ-032 Mode 0: every pixel = color.
REQ-033 Mode 1: bar index = x*8/CAM_SCREEN_X, integer, 0..7; index bits {b2,b1,b0} map to R=4'hF if b2 else 0, G=4'hF if b1 else 0, B=4'hF if b0 else 0.
REQ-034 Mode 2: R = x[7:4], G = 0, B = 0.
REQ-035 Mode 3: pixel = 12'hFFF if x[3]^y[3] is 1, else 12'h000.
REQ-036 Counters shall be sized with $clog2 of their maximum value; no counter may wrap within a state.

Reset
REQ-037 While rst=0, the FSM shall be in IDLE and CAM_pclk, CAM_vsync, CAM_href, CAM_px_data and frame_done shall all be 0, with all counters cleared.
REQ-038 Asserting rst mid-frame shall abort the frame immediately, and no frame_done shall be issued for it.
REQ-039 After rst deasserts with en=1, the first CAM_vsync rise shall occur within 2 clk.

Verification
REQ-040 Timing: defaults, mode 0, color=12'hA5C, en=1 for one frame -> CAM_vsync high for 1392 pclk; 120 CAM_href pulses of 320 pclk each, separated by 144 pclk; bytes alternate 8'h0A, 8'h5C; 1 frame_done.
REQ-041 Bars: mode 1 -> line 0 pixel 0 = 12'h000, pixel 20 = 12'h00F, pixel 159 = 12'hFFF (bytes 8'h0F, 8'hFF).
REQ-042 Checker: mode 3 -> pixel (8,0) = 12'hFFF, pixel (8,8) = 12'h000, pixel (0,0) = 12'h000.
REQ-043 Control: en dropped at line 50 -> frame completes, frame_done pulses once, FSM returns to IDLE, CAM_pclk low; mode changed mid-frame -> takes effect only in the next frame.
REQ-044 Reset: rst=0 during ACTIVE -> all outputs 0 within 1 clk, no frame_done; after release the next frame restarts at y=0.
REQ-045 Loopback: output fed into the team's capture block -> the captured RAM image matches the pattern at all 19200 addresses for modes 1-3.
